rr_arb4: RTL
============

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum GRANT cycles per ownership (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  4  request lines, bit i = requester i; may change any cycle.
REQ-005 done  input  1  owner releases its grant; ignored outside GRANT.
REQ-006 gnt  output  4  registered grant; one-hot in GRANT, all zero otherwise; feeds the downstream 4-to-2 encoder.
REQ-007 gnt_valid  output  1  registered; high exactly when gnt is non-zero.

Function
REQ-008 The block SHALL implement two states: IDLE and GRANT.
REQ-009 IDLE, req == 0: the block SHALL stay in IDLE with gnt = 0 and gnt_valid = 0.
REQ-010 IDLE, req != 0 at edge k: the block SHALL enter GRANT and drive the winner's one-hot gnt with gnt_valid = 1 after edge k (one-cycle latency).
REQ-011 Winner selection SHALL be round-robin: scan order last+1, last+2, last+3, last (mod 4); first set req bit wins.
REQ-012 The register last (2 bits) SHALL load the winner index when GRANT is entered.
REQ-013 In GRANT, gnt SHALL hold constant regardless of other req bits.
REQ-014 GRANT SHALL end at the next edge on the first of:
  - done == 1;
  - req[owner] == 0;
  - hold counter == MAX_HOLD-1.
REQ-015 On ending GRANT the block SHALL return to IDLE with gnt = 0 for at least one full cycle before any new grant.
REQ-016 The hold counter SHALL clear on GRANT entry, increment each GRANT cycle, and never wrap (bounded by REQ-014).
REQ-017 Simultaneous release conditions SHALL be treated as a single release, with no extra or missing cycle.
REQ-018 gnt SHALL never have more than one bit set in any cycle.
REQ-019 A sole persistent requester SHALL be re-granted after each mandatory IDLE cycle.

Reset
REQ-020 While rst is high at an edge, the block SHALL set state = IDLE, gnt = 4'b0000, gnt_valid = 0, hold counter = 0, and last = 2'd3 (req[0] has first priority).
REQ-021 rst during GRANT SHALL drop gnt to zero at that edge.
REQ-022 rst SHALL take precedence over req and done in the same cycle.
REQ-023 The first grant SHALL be possible at the edge after rst deasserts.

Structure
REQ-024 A shared package SHALL hold:
  - state encoding constants IDLE = 1'b0 and GRANT = 1'b1;
  - constant LAST_RST = 2'd3;
  - constant NREQ = 4.
REQ-025 One combinational sub-module rr_pick4 SHALL take (req, last) and produce one-hot pick plus a 2-bit pick index; rr_arb4 instantiates it once.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from req or done to gnt.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - Reset release, req = 4'b0001 -> gnt = 4'b0001 and gnt_valid = 1 one cycle later; done pulse -> gnt = 0 for one cycle.
  - req = 4'b1111 held, done pulsed every grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, each separated by one zero cycle.
  - req = 4'b0010 held, done = 0, MAX_HOLD = 8 -> gnt = 0010 for exactly 8 cycles, 1 zero cycle, then 0010 again.
  - In GRANT to bit 2, drop req[2] while req[0] is high -> gnt = 0 next cycle, then 0001.
  - rst asserted mid-GRANT -> gnt = 0 and gnt_valid = 0 at that edge; after release, req = 4'b1010 -> gnt = 0010 (last reset to 3).
  - Every cycle: one-hot-or-zero check on gnt, and gnt_valid == |gnt.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared constants and state type for the 4-way round-robin arbiter.
package rr_arb4_pkg;
  localparam int         NREQ     = 4;
  localparam logic [1:0] LAST_RST = 2'd3;  // req[0] wins first after reset

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans last+1 .. last (mod 4), first set
// request wins. Produces a one-hot pick and its index; all-zero when req == 0.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] pick,
  output logic [1:0]      idx
);

  logic [1:0] cand;
  logic       found;

  // walk the rotated priority order, latching the first requester seen
  always_comb begin
    pick  = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// 4-requester round-robin arbiter with a bounded hold time. A grant lasts
// until done, the owner dropping its request, or MAX_HOLD cycles, and every
// ownership is followed by at least one idle cycle. All outputs are flops.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid
);

  localparam logic [7:0] HOLD_END = 8'(MAX_HOLD - 1);

  state_t     state, nxt_state;
  logic [1:0] last, nxt_last;
  logic [7:0] hold, nxt_hold;
  logic [3:0] nxt_gnt;
  logic [3:0] pick;
  logic [1:0] pidx;
  logic       rel;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .idx  (pidx)
  );

  // next-state logic; in GRANT 'last' is the owner index, so it selects the
  // owner's request bit for the release test
  always_comb begin
    nxt_state = state;
    nxt_gnt   = gnt;
    nxt_last  = last;
    nxt_hold  = hold;
    rel       = done | ~req[last] | (hold == HOLD_END);
    case (state)
      IDLE: begin
        nxt_gnt  = '0;
        nxt_hold = '0;
        if (|req) begin
          nxt_state = GRANT;
          nxt_gnt   = pick;
          nxt_last  = pidx;
        end
      end
      GRANT: begin
        if (rel) begin
          nxt_state = IDLE;
          nxt_gnt   = '0;
          nxt_hold  = '0;
        end else begin
          nxt_hold = hold + 8'd1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_gnt   = '0;
        nxt_hold  = '0;
      end
    endcase
  end

  // state and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      hold      <= '0;
      last      <= LAST_RST;
    end else begin
      state     <= nxt_state;
      gnt       <= nxt_gnt;
      gnt_valid <= (nxt_state == GRANT);
      hold      <= nxt_hold;
      last      <= nxt_last;
    end
  end

endmodule
